// File: rtl/blockade_loader.sv
// blockade_loader: buffers the HPS ROM download into core ROM writes and holds the core in reset until the image is loaded.
// Ports:
//   clk, reset                    - system clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout - HPS download stream (only index 0 is ROM data)
//   ioctl_wait                    - back-pressure to HPS, raised at occupancy FIFO_DEPTH-1
//   dn_addr/dn_data/dn_wr         - paced ROM write port into the core (max 1 write per 2 clk)
//   core_reset                    - high until the image is written and the hold time has elapsed
//   load_done/load_error          - load finished / last load was short, long, overflowed or out of range
//   byte_count                    - in-range bytes accepted in the current/last load
module blockade_loader #(
    parameter int EXPECTED_BYTES = 4608,
    parameter int RESET_HOLD     = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [12:0] byte_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [16:0] EXP_ADDR  = 17'(EXPECTED_BYTES);
    localparam logic [13:0] EXP_CNT   = 14'(EXPECTED_BYTES);
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] WAIT_LVL  = (AW + 1)'(FIFO_DEPTH - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOADING, S_DRAIN, S_HOLD, S_DONE} state_t;

    state_t        r_state, w_next;
    logic          r_dl_prev;
    logic [21:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, w_cnt_next;
    logic [15:0]   r_hold;
    logic          r_range_err, r_ovf_err, r_load_error;
    logic          r_wait, r_dn_wr;
    logic [13:0]   r_dn_addr;
    logic [7:0]    r_dn_data;
    logic [12:0]   r_count;
    logic          w_start, w_in_range, w_full, w_empty, w_push, w_pop, w_to_hold, w_wr_ld;

    always_comb begin
        w_start    = ioctl_download && (ioctl_index == 8'd0) && !r_dl_prev;
        w_in_range = {1'b0, ioctl_addr} < EXP_ADDR;
        w_full     = r_cnt == FULL_LVL;
        w_empty    = r_cnt == '0;
        w_wr_ld    = (r_state == S_LOADING) && ioctl_wr;
        w_push     = w_wr_ld && w_in_range && !w_full;
        // a pop is blocked while the previous write is still on the bus, forcing a gap cycle
        w_pop      = ((r_state == S_LOADING) || (r_state == S_DRAIN)) && !w_empty && !r_dn_wr;
        w_cnt_next = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        w_to_hold  = (r_state == S_DRAIN) && w_empty && !r_dn_wr;
    end

    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = S_LOADING;
        else
            case (r_state)
                S_LOADING: w_next = ioctl_download ? S_LOADING : S_DRAIN;
                S_DRAIN:   w_next = w_to_hold ? S_HOLD : S_DRAIN;
                S_HOLD:    w_next = (r_hold == HOLD_LAST) ? S_DONE : S_HOLD;
                default:   w_next = r_state;
            endcase
    end

    // tracked through reset so a download still in progress is not seen as a new one
    always_ff @(posedge clk)
        r_dl_prev <= ioctl_download;

    always_ff @(posedge clk)
        if (w_push)
            r_mem[r_wp] <= {ioctl_addr[13:0], ioctl_dout};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_wait       <= 1'b0;
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_count      <= '0;
            r_range_err  <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= (r_state == S_HOLD) ? r_hold + 16'd1 : '0;
            r_dn_wr <= w_pop && !w_start;
            if (w_pop && !w_start)
                {r_dn_addr, r_dn_data} <= r_mem[r_rp];
            if (w_start) begin
                r_wp         <= '0;
                r_rp         <= '0;
                r_cnt        <= '0;
                r_wait       <= 1'b0;
                r_count      <= '0;
                r_range_err  <= 1'b0;
                r_ovf_err    <= 1'b0;
                r_load_error <= 1'b0;
            end else begin
                r_wp   <= r_wp + AW'(w_push);
                r_rp   <= r_rp + AW'(w_pop);
                r_cnt  <= w_cnt_next;
                // based on next occupancy so a strobe one cycle late still fits
                r_wait <= w_cnt_next >= WAIT_LVL;
                if (w_push && (r_count != 13'h1FFF))
                    r_count <= r_count + 13'd1;
                if (w_wr_ld && !w_in_range)
                    r_range_err <= 1'b1;
                if (w_wr_ld && w_full)
                    r_ovf_err <= 1'b1;
                if (w_to_hold)
                    r_load_error <= ({1'b0, r_count} != EXP_CNT) || r_range_err || r_ovf_err;
            end
        end
    end

    assign ioctl_wait = r_wait;
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_wr      = r_dn_wr;
    assign core_reset = r_state != S_DONE;
    assign load_done  = r_state == S_DONE;
    assign load_error = r_load_error;
    assign byte_count = r_count;
endmodule
